// File: rtl/multi_book_engine.sv
// Multi-instrument order book engine: direct-mapped order map plus unsorted per-book/side
// price-level tables, one message in flight, emits the touched book's top of book on change.
module multi_book_engine #(
  parameter int NUM_BOOKS = 4,
  parameter int LEVELS    = 8,
  parameter int MAP_DEPTH = 256
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        msgValidIn,
  output logic        msgReadyOut,
  input  logic [1:0]  msgTypeIn,
  input  logic [63:0] refNumIn,
  input  logic [15:0] locateIn,
  input  logic [31:0] priceIn,
  input  logic [31:0] sharesIn,
  input  logic        buySellIn,
  output logic        topValidOut,
  output logic [15:0] topLocateOut,
  output logic [31:0] topBuyPriceOut,
  output logic [31:0] topBuyQtyOut,
  output logic [31:0] topSellPriceOut,
  output logic [31:0] topSellQtyOut,
  output logic        errValidOut,
  output logic [2:0]  errCodeOut
);
  localparam int BW  = (NUM_BOOKS > 1) ? $clog2(NUM_BOOKS) : 1;
  localparam int SW  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int IW  = $clog2(MAP_DEPTH);
  localparam int TBL = 2 ** (BW + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_LEVEL_SCAN, S_UPDATE, S_TOP_SCAN, S_EMIT, S_ERR} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_DEL, OP_EXEC, OP_CANCEL} op_t;
  typedef enum logic [2:0] {E_NONE = 3'd0, E_COLLIDE = 3'd1, E_NOREF = 3'd2, E_FULL = 3'd3,
                            E_LOCATE = 3'd4} err_t;

  state_t state, next_state;
  err_t   err_code, err_next;
  op_t    m_op;
  logic [63:0] m_ref;
  logic [15:0] m_loc;
  logic [31:0] m_px, m_sh;
  logic        m_side;

  logic [BW-1:0] w_book;
  logic [31:0]   w_px, w_osh;
  logic          w_side;
  logic [SW-1:0] scan, match_slot, free_slot;
  logic          match_found, free_found;
  logic          best_valid, changed;
  logic [31:0]   best_px, best_qty;

  logic [MAP_DEPTH-1:0] map_valid;
  logic [63:0]   map_tag  [MAP_DEPTH];
  logic [BW-1:0] map_book [MAP_DEPTH];
  logic [31:0]   map_px   [MAP_DEPTH];
  logic [31:0]   map_sh   [MAP_DEPTH];
  logic          map_side [MAP_DEPTH];

  logic [LEVELS-1:0] lv_valid [TBL];
  logic [31:0]       lv_px    [TBL][LEVELS];
  logic [31:0]       lv_qty   [TBL][LEVELS];
  logic [31:0]       top_px   [TBL];
  logic [31:0]       top_qty  [TBL];

  logic [IW-1:0] idx;
  logic [BW:0]   tbl, tbl_other;
  logic          map_hit, slot_v, last, match_now, free_now, take, fin_valid, top_diff;
  logic [SW-1:0] match_idx, free_idx;
  logic [31:0]   slot_px, slot_qty, fin_px, fin_qty, new_px, new_qty;
  logic [31:0]   dec, osh_left, lvl_left, add_qty;
  logic [32:0]   lvl_sum;

  assign idx         = m_ref[IW-1:0];
  assign tbl         = {w_book, w_side};
  assign tbl_other   = {w_book, ~w_side};
  assign msgReadyOut = (state == S_IDLE) && !rstIn;
  assign errValidOut = (state == S_ERR) && !rstIn;
  assign topValidOut = (state == S_EMIT) && changed && !rstIn;
  assign errCodeOut  = err_code;

  always_comb begin
    map_hit   = map_valid[idx] && (map_tag[idx] == m_ref);
    slot_v    = lv_valid[tbl][scan];
    slot_px   = lv_px[tbl][scan];
    slot_qty  = lv_qty[tbl][scan];
    last      = (scan == SW'(LEVELS - 1));
    match_now = match_found || (slot_v && (slot_px == w_px));
    match_idx = match_found ? match_slot : scan;
    free_now  = free_found || !slot_v;
    free_idx  = free_found ? free_slot : scan;
    // Buy side keeps the highest price, sell side the lowest.
    take      = slot_v && (!best_valid || (w_side ? (slot_px > best_px) : (slot_px < best_px)));
    fin_valid = best_valid || slot_v;
    fin_px    = take ? slot_px : best_px;
    fin_qty   = take ? slot_qty : best_qty;
    new_px    = fin_valid ? fin_px : (w_side ? '0 : '1);
    new_qty   = fin_valid ? fin_qty : '0;
    top_diff  = (new_px != top_px[tbl]) || (new_qty != top_qty[tbl]);
    dec       = ((m_op == OP_DEL) || (m_sh > w_osh)) ? w_osh : m_sh;
    osh_left  = w_osh - dec;
    lvl_left  = lv_qty[tbl][match_slot] - dec;
    lvl_sum   = {1'b0, lv_qty[tbl][match_slot]} + {1'b0, m_sh};
    add_qty   = lvl_sum[32] ? '1 : lvl_sum[31:0];
    next_state = state;
    err_next   = err_code;
    case (state)
      S_IDLE: if (msgValidIn) next_state = S_LOOKUP;
      S_LOOKUP: begin
        next_state = S_LEVEL_SCAN;
        if (m_op == OP_ADD) begin
          if (m_loc >= 16'(NUM_BOOKS)) begin
            next_state = S_ERR;
            err_next   = E_LOCATE;
          end else if (map_valid[idx]) begin
            next_state = S_ERR;
            err_next   = E_COLLIDE;
          end
        end else if (!map_hit) begin
          next_state = S_ERR;
          err_next   = E_NOREF;
        end
      end
      S_LEVEL_SCAN: if (last) begin
        next_state = S_UPDATE;
        if ((m_op == OP_ADD) && !match_now && !free_now) begin
          next_state = S_ERR;
          err_next   = E_FULL;
        end else if ((m_op != OP_ADD) && !match_now) begin
          next_state = S_ERR;
          err_next   = E_NOREF;
        end
      end
      S_UPDATE:   next_state = S_TOP_SCAN;
      S_TOP_SCAN: if (last) next_state = S_EMIT;
      default:    next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state           <= S_IDLE;
      err_code        <= E_NONE;
      changed         <= 1'b0;
      map_valid       <= '0;
      topLocateOut    <= '0;
      topBuyPriceOut  <= '0;
      topBuyQtyOut    <= '0;
      topSellPriceOut <= '0;
      topSellQtyOut   <= '0;
      for (int unsigned t = 0; t < TBL; t++) begin
        lv_valid[t] <= '0;
        top_px[t]   <= t[0] ? '0 : '1;
        top_qty[t]  <= '0;
      end
    end else begin
      state    <= next_state;
      err_code <= err_next;
      case (state)
        S_IDLE: if (msgValidIn) begin
          m_op   <= op_t'(msgTypeIn);
          m_ref  <= refNumIn;
          m_loc  <= locateIn;
          m_px   <= priceIn;
          m_sh   <= sharesIn;
          m_side <= buySellIn;
        end
        S_LOOKUP: begin
          if (m_op == OP_ADD) begin
            w_book <= m_loc[BW-1:0];
            w_px   <= m_px;
            w_side <= m_side;
            w_osh  <= m_sh;
          end else begin
            w_book <= map_book[idx];
            w_px   <= map_px[idx];
            w_side <= map_side[idx];
            w_osh  <= map_sh[idx];
          end
          scan        <= '0;
          match_found <= 1'b0;
          free_found  <= 1'b0;
        end
        S_LEVEL_SCAN: begin
          scan        <= last ? '0 : scan + 1'b1;
          match_found <= match_now;
          match_slot  <= match_idx;
          free_found  <= free_now;
          free_slot   <= free_idx;
        end
        S_UPDATE: begin
          scan       <= '0;
          best_valid <= 1'b0;
          if (m_op == OP_ADD) begin
            map_valid[idx] <= 1'b1;
            if (!match_found) lv_valid[tbl][free_slot] <= 1'b1;
          end else begin
            if ((m_op == OP_DEL) || (osh_left == '0)) map_valid[idx] <= 1'b0;
            if (lvl_left == '0) lv_valid[tbl][match_slot] <= 1'b0;
          end
        end
        S_TOP_SCAN: begin
          scan       <= last ? '0 : scan + 1'b1;
          best_valid <= fin_valid;
          best_px    <= fin_px;
          best_qty   <= fin_qty;
          if (last) begin
            changed <= top_diff;
            if (top_diff) begin
              top_px[tbl]  <= new_px;
              top_qty[tbl] <= new_qty;
              topLocateOut <= 16'(w_book);
              if (w_side) begin
                topBuyPriceOut  <= new_px;
                topBuyQtyOut    <= new_qty;
                topSellPriceOut <= top_px[tbl_other];
                topSellQtyOut   <= top_qty[tbl_other];
              end else begin
                topBuyPriceOut  <= top_px[tbl_other];
                topBuyQtyOut    <= top_qty[tbl_other];
                topSellPriceOut <= new_px;
                topSellQtyOut   <= new_qty;
              end
            end
          end
        end
        S_EMIT:  changed <= 1'b0;
        default: ;
      endcase
    end
  end

  // Payload storage has no reset; the valid bits above gate every read.
  always_ff @(posedge clkIn) begin
    if (!rstIn && (state == S_UPDATE)) begin
      if (m_op == OP_ADD) begin
        map_tag[idx]  <= m_ref;
        map_book[idx] <= w_book;
        map_px[idx]   <= w_px;
        map_sh[idx]   <= m_sh;
        map_side[idx] <= w_side;
        if (match_found) begin
          lv_qty[tbl][match_slot] <= add_qty;
        end else begin
          lv_px[tbl][free_slot]  <= w_px;
          lv_qty[tbl][free_slot] <= m_sh;
        end
      end else begin
        map_sh[idx]             <= osh_left;
        lv_qty[tbl][match_slot] <= lvl_left;
      end
    end
  end
endmodule

// File: tb/tb_multi_book_engine.sv
// Directed bench for multi_book_engine: queue-based reference book model plus literal pins.
module tb_multi_book_engine;
  logic        clkIn = 1'b0;
  logic        rstIn, msgValidIn, msgReadyOut, buySellIn;
  logic [1:0]  msgTypeIn;
  logic [63:0] refNumIn;
  logic [15:0] locateIn, topLocateOut;
  logic [31:0] priceIn, sharesIn;
  logic        topValidOut, errValidOut;
  logic [31:0] topBuyPriceOut, topBuyQtyOut, topSellPriceOut, topSellQtyOut;
  logic [2:0]  errCodeOut;

  multi_book_engine #(.NUM_BOOKS(4), .LEVELS(8), .MAP_DEPTH(256)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .msgValidIn(msgValidIn), .msgReadyOut(msgReadyOut),
    .msgTypeIn(msgTypeIn), .refNumIn(refNumIn), .locateIn(locateIn), .priceIn(priceIn),
    .sharesIn(sharesIn), .buySellIn(buySellIn), .topValidOut(topValidOut),
    .topLocateOut(topLocateOut), .topBuyPriceOut(topBuyPriceOut), .topBuyQtyOut(topBuyQtyOut),
    .topSellPriceOut(topSellPriceOut), .topSellQtyOut(topSellQtyOut),
    .errValidOut(errValidOut), .errCodeOut(errCodeOut)
  );

  always #5 clkIn = ~clkIn;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: orders by map index, levels as queues per (book, side), stored tops.
  typedef struct { logic [31:0] px; logic [31:0] qty; } lvl_t;
  lvl_t        lv [8][$];
  bit          o_valid [256];
  logic [63:0] o_ref   [256];
  int          o_book  [256];
  logic [31:0] o_px    [256];
  logic        o_side  [256];
  logic [31:0] o_sh    [256];
  logic [31:0] mt_px [8];
  logic [31:0] mt_qty[8];
  logic [15:0] mo_loc;
  logic [31:0] mo_bp, mo_bq, mo_sp, mo_sq;
  int e_kind, e_code, e_at, e_ready;   // e_kind: 0 silent, 1 top pulse, 2 error pulse

  task automatic model_reset();
    for (int t = 0; t < 8; t++) begin
      lv[t].delete();
      mt_px[t]  = (t % 2 == 1) ? 32'd0 : 32'hFFFF_FFFF;
      mt_qty[t] = 32'd0;
    end
    for (int i = 0; i < 256; i++) o_valid[i] = 1'b0;
    mo_loc = '0; mo_bp = '0; mo_bq = '0; mo_sp = '0; mo_sq = '0;
  endtask

  task automatic set_err(input int code, input int at);
    e_kind = 2; e_code = code; e_at = at; e_ready = at + 1;
  endtask

  task automatic model_msg(input logic [1:0] typ, input logic [63:0] r, input logic [15:0] loc,
                           input logic [31:0] px, input logic [31:0] sh, input logic side);
    int idx, b, t, li;
    logic [31:0] p, d, bp, bq;
    logic s;
    logic [32:0] sum;
    lvl_t e;
    bit found;
    idx = int'(r[7:0]);
    e_kind = 0; e_code = 0; e_at = 19; e_ready = 20;
    if (typ == 2'd0) begin
      if (loc >= 16'd4) begin set_err(4, 2); return; end
      if (o_valid[idx]) begin set_err(1, 2); return; end
      b = int'(loc); p = px; s = side;
    end else begin
      if (!(o_valid[idx] && o_ref[idx] == r)) begin set_err(2, 2); return; end
      b = o_book[idx]; p = o_px[idx]; s = o_side[idx];
    end
    t = b * 2 + int'(s);
    li = -1;
    for (int i = 0; i < lv[t].size(); i++) if (lv[t][i].px == p) li = i;
    if (typ == 2'd0 && li < 0 && lv[t].size() == 8) begin set_err(3, 10); return; end
    if (typ != 2'd0 && li < 0) begin set_err(2, 10); return; end
    if (typ == 2'd0) begin
      o_valid[idx] = 1'b1; o_ref[idx] = r; o_book[idx] = b;
      o_px[idx] = p; o_side[idx] = s; o_sh[idx] = sh;
      if (li >= 0) begin
        e = lv[t][li];
        sum = {1'b0, e.qty} + {1'b0, sh};
        e.qty = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
        lv[t][li] = e;
      end else begin
        e.px = p; e.qty = sh;
        lv[t].push_back(e);
      end
    end else begin
      d = (typ == 2'd1 || sh > o_sh[idx]) ? o_sh[idx] : sh;
      o_sh[idx] = o_sh[idx] - d;
      if (typ == 2'd1 || o_sh[idx] == 0) o_valid[idx] = 1'b0;
      e = lv[t][li];
      e.qty = e.qty - d;
      if (e.qty == 0) lv[t].delete(li);
      else lv[t][li] = e;
    end
    found = 0; bp = s ? 32'd0 : 32'hFFFF_FFFF; bq = 32'd0;
    for (int i = 0; i < lv[t].size(); i++) begin
      if (!found || (s ? (lv[t][i].px > bp) : (lv[t][i].px < bp))) begin
        bp = lv[t][i].px; bq = lv[t][i].qty; found = 1;
      end
    end
    if (bp != mt_px[t] || bq != mt_qty[t]) begin
      mt_px[t] = bp; mt_qty[t] = bq;
      e_kind = 1;
      mo_loc = 16'(b);
      mo_bp = mt_px[b*2+1]; mo_bq = mt_qty[b*2+1];
      mo_sp = mt_px[b*2];   mo_sq = mt_qty[b*2];
    end
  endtask

  task automatic send(input logic [1:0] typ, input logic [63:0] r, input logic [15:0] loc,
                      input logic [31:0] px, input logic [31:0] sh, input logic side);
    int w;
    model_msg(typ, r, loc, px, sh, side);
    @(negedge clkIn);
    msgTypeIn = typ; refNumIn = r; locateIn = loc; priceIn = px; sharesIn = sh; buySellIn = side;
    msgValidIn = 1'b1;
    w = 0;
    while (!msgReadyOut && w < 50) begin @(negedge clkIn); w++; end
    if (!msgReadyOut) begin
      check("accept_timeout", 64'(msgReadyOut), 64'd1);
      msgValidIn = 1'b0;
      return;
    end
    @(posedge clkIn);
    #1 msgValidIn = 1'b0;
    for (int c = 1; c <= e_ready; c++) begin
      @(negedge clkIn);
      check($sformatf("flags_c%0d ref%0d", c, r), {errValidOut, topValidOut, msgReadyOut},
            {(e_kind == 2 && c == e_at), (e_kind == 1 && c == e_at), (c == e_ready)});
      if (c == e_at && e_kind == 2) check("err_code", 64'(errCodeOut), 64'(e_code));
      if (c == e_ready) begin
        check("top_loc", 64'(topLocateOut), 64'(mo_loc));
        check("top_bid", {topBuyPriceOut, topBuyQtyOut}, {mo_bp, mo_bq});
        check("top_ask", {topSellPriceOut, topSellQtyOut}, {mo_sp, mo_sq});
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstIn = 1'b1; msgValidIn = 1'b0; msgTypeIn = '0; refNumIn = '0; locateIn = '0;
    priceIn = '0; sharesIn = '0; buySellIn = 1'b0;
    model_reset();
    repeat (3) @(negedge clkIn);
    check("rst_ready", 64'(msgReadyOut), 64'd0);
    check("rst_flags", {errValidOut, topValidOut}, 64'd0);
    check("rst_top", {topBuyPriceOut, topSellPriceOut}, 64'd0);
    check("rst_code", 64'(errCodeOut), 64'd0);
    rstIn = 1'b0;

    send(2'd0, 64'd5, 16'd1, 32'd100, 32'd10, 1'b1);
    check("t1_bid", {topBuyPriceOut, topBuyQtyOut}, {32'd100, 32'd10});
    check("t1_ask", {topSellPriceOut, topSellQtyOut}, {32'hFFFF_FFFF, 32'd0});
    check("t1_loc", 64'(topLocateOut), 64'd1);
    send(2'd0, 64'd6, 16'd1, 32'd100, 32'd5, 1'b1);
    check("t2_bid", {topBuyPriceOut, topBuyQtyOut}, {32'd100, 32'd15});
    send(2'd0, 64'd7, 16'd1, 32'd99, 32'd3, 1'b1);
    check("t2_hold", {topBuyPriceOut, topBuyQtyOut}, {32'd100, 32'd15});
    send(2'd0, 64'd261, 16'd1, 32'd50, 32'd1, 1'b1);
    check("t4_collide", 64'(errCodeOut), 64'd1);

    send(2'd2, 64'd5, 16'd0, 32'd0, 32'd4, 1'b0);
    check("t3_exec", {topBuyPriceOut, topBuyQtyOut}, {32'd100, 32'd11});
    send(2'd1, 64'd6, 16'd0, 32'd0, 32'd0, 1'b0);
    check("t3_del", {topBuyPriceOut, topBuyQtyOut}, {32'd100, 32'd6});
    send(2'd3, 64'd5, 16'd0, 32'd0, 32'd50, 1'b0);
    check("t3_cancel", {topBuyPriceOut, topBuyQtyOut}, {32'd99, 32'd3});
    send(2'd1, 64'd5, 16'd0, 32'd0, 32'd0, 1'b0);
    check("t3_freed", 64'(errCodeOut), 64'd2);

    send(2'd1, 64'd999, 16'd0, 32'd0, 32'd0, 1'b0);
    check("t4_noref", 64'(errCodeOut), 64'd2);
    send(2'd0, 64'd300, 16'd9, 32'd10, 32'd1, 1'b1);
    check("t4_locate", 64'(errCodeOut), 64'd4);
    send(2'd2, 64'd7, 16'd0, 32'd0, 32'd3, 1'b0);
    check("exec_empty", {topBuyPriceOut, topBuyQtyOut}, 64'd0);

    for (int i = 0; i < 9; i++)
      send(2'd0, 64'(20 + i), 16'd0, 32'(200 - 10 * i), 32'(i + 1), 1'b0);
    check("t5_full", 64'(errCodeOut), 64'd3);
    check("t5_ask", {topSellPriceOut, topSellQtyOut}, {32'd130, 32'd8});
    check("t5_loc", 64'(topLocateOut), 64'd0);

    send(2'd0, 64'd30, 16'd3, 32'd77, 32'hFFFF_FFF0, 1'b0);
    send(2'd0, 64'd31, 16'd3, 32'd77, 32'h20, 1'b0);
    check("sat_ask", {topSellPriceOut, topSellQtyOut}, {32'd77, 32'hFFFF_FFFF});
    send(2'd2, 64'd31, 16'd0, 32'd0, 32'd1, 1'b0);
    check("sat_exec", 64'(topSellQtyOut), 64'hFFFF_FFFE);

    // Reset lands in the TOP_SCAN window of an ADD.
    @(negedge clkIn);
    msgTypeIn = 2'd0; refNumIn = 64'd40; locateIn = 16'd2; priceIn = 32'd300;
    sharesIn = 32'd7; buySellIn = 1'b1; msgValidIn = 1'b1;
    check("t6_ready", 64'(msgReadyOut), 64'd1);
    @(posedge clkIn);
    #1 msgValidIn = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clkIn);
      check($sformatf("t6_flags_c%0d", c), {errValidOut, topValidOut, msgReadyOut}, 64'd0);
    end
    rstIn = 1'b1;
    #1 check("t6_rst_ready", 64'(msgReadyOut), 64'd0);
    @(negedge clkIn);
    check("t6_rst_flags", {errValidOut, topValidOut, msgReadyOut}, 64'd0);
    check("t6_rst_tops", {topBuyPriceOut, topSellPriceOut}, 64'd0);
    check("t6_rst_qty", {topBuyQtyOut, topSellQtyOut}, 64'd0);
    check("t6_rst_loc", 64'(topLocateOut), 64'd0);
    rstIn = 1'b0;
    model_reset();
    @(negedge clkIn);
    check("t6_ready_after", {topValidOut, msgReadyOut}, 64'd1);
    send(2'd1, 64'd40, 16'd0, 32'd0, 32'd0, 1'b0);
    check("t6_del", 64'(errCodeOut), 64'd2);
    send(2'd0, 64'd41, 16'd2, 32'd500, 32'd1, 1'b0);
    check("t6_book2", {topBuyPriceOut, topBuyQtyOut, topSellPriceOut[15:0], topSellQtyOut[15:0]},
          {32'd0, 32'd0, 16'd500, 16'd1});
    send(2'd0, 64'd42, 16'd1, 32'd10, 32'd1, 1'b1);
    check("t6_book1_bid", {topBuyPriceOut, topBuyQtyOut}, {32'd10, 32'd1});
    check("t6_book1_ask", {topSellPriceOut, topSellQtyOut}, {32'hFFFF_FFFF, 32'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
